// File: rtl/vectadd_from_hw_data.sv
// vectadd_from_hw_data: Avalon-MM read-side status port for the vector-add
// hardware. Synchronizes a WIDTH-bit hardware bus into clk, exposes it as
// DATA, latches per-bit edges in a sticky write-1-to-clear EDGECAPTURE
// register and raises a level irq for captured bits enabled in IRQMASK.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   address[1:0]          word address: 0 DATA, 1 reserved, 2 IRQMASK, 3 EDGECAPTURE
//   chipselect, write_n   write qualifier is chipselect && !write_n
//   writedata[31:0]       write data (bits above WIDTH ignored)
//   in_port[WIDTH-1:0]    hardware input bus, asynchronous to clk
//   readdata[31:0]        combinational read mux, zero-extended above WIDTH
//   irq                   level interrupt, driven straight from a flop
module vectadd_from_hw_data #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned BUS_W = 32;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] ec_q, ec_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] wdata;
  logic             wr_en;

  assign din   = sync_q[SYNC_STAGES-1];
  assign wdata = writedata[WIDTH-1:0];
  assign wr_en = chipselect && !write_n;

  // Per-bit edge event between the synchronized value and its previous sample.
  always_comb begin
    edge_det = din ^ prev_q;
    if (EDGE_TYPE == 0) begin
      edge_det = din & ~prev_q;
    end else if (EDGE_TYPE == 1) begin
      edge_det = ~din & prev_q;
    end
  end

  // Next-state for synchronizer, history, mask, capture and irq.
  always_comb begin
    sync_d = sync_q;
    prev_d = din;
    mask_d = mask_q;
    ec_d   = edge_det | ec_q;

    sync_d[0] = in_port;
    for (int k = 1; k < int'(SYNC_STAGES); k++) begin
      sync_d[k] = sync_q[k-1];
    end

    if (wr_en && address == ADDR_MASK) begin
      mask_d = wdata;
    end
    // Clear applies only to the held value, so a same-cycle edge wins.
    if (wr_en && address == ADDR_EDGE) begin
      ec_d = edge_det | (ec_q & ~wdata);
    end

    // irq is computed from next-state so it updates at the same edge as
    // the registers it summarizes, but is itself a flop (glitch-free).
    irq_d = |(ec_d & mask_d);
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
      mask_q <= '0;
      ec_q   <= '0;
      irq_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      mask_q <= mask_d;
      ec_q   <= ec_d;
      irq_q  <= irq_d;
    end
  end

  // Zero-latency read mux; all sources are registers, so reads are 0 in reset.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata = BUS_W'(din);
      ADDR_MASK: readdata = BUS_W'(mask_q);
      ADDR_EDGE: readdata = BUS_W'(ec_q);
      default:   readdata = '0;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_vectadd_from_hw_data.sv
module tb_vectadd_from_hw_data;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] in_port;

  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  int checks   = 0;
  int failures = 0;

  // Three configurations sharing one bus and one input stimulus.
  vectadd_from_hw_data #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0));

  vectadd_from_hw_data #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port[7:0]),
    .readdata(rd1), .irq(irq1));

  vectadd_from_hw_data #(.WIDTH(8), .SYNC_STAGES(3), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port[7:0]),
    .readdata(rd2), .irq(irq2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-configuration properties.
  function automatic logic [31:0] wmask(int i);
    return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
  endfunction
  function automatic int sstg(int i);
    return (i == 2) ? 3 : 2;
  endfunction
  function automatic int etype(int i);
    return i;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // hist[c] is the bus value captured by the first synchronizer stage at edge c
  // (0 for edges during reset). After edge c the DUT's DATA equals
  // hist[c-S+1]; any entry at or before an asynchronous reset reads as 0.
  logic [31:0] hist [0:4095];
  int          cyc       = 0;
  int          zero_upto = -1;
  logic [31:0] ec_m   [3];
  logic [31:0] mask_m [3];

  function automatic logic [31:0] h(int k);
    if (k < 0 || k <= zero_upto) return 32'h0;
    return hist[k];
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) begin
      ec_m[i]   = '0;
      mask_m[i] = '0;
    end
  end

  always @(negedge reset_n) begin
    zero_upto = cyc;
    for (int i = 0; i < 3; i++) begin
      ec_m[i]   = '0;
      mask_m[i] = '0;
    end
  end

  always @(posedge clk) begin
    logic [31:0] d, p, ev, clr, wm;
    bit          wr;
    cyc = cyc + 1;
    hist[cyc] = reset_n ? in_port : 32'h0;
    wr = chipselect && !write_n;
    if (reset_n) begin
      for (int i = 0; i < 3; i++) begin
        wm = wmask(i);
        d  = h(cyc - sstg(i)) & wm;
        p  = h(cyc - sstg(i) - 1) & wm;
        case (etype(i))
          0:       ev = d & ~p;
          1:       ev = ~d & p;
          default: ev = d ^ p;
        endcase
        clr = (wr && address == 2'd3) ? (writedata & wm) : 32'h0;
        ec_m[i] = (ev | (ec_m[i] & ~clr)) & wm;
        if (wr && address == 2'd2) mask_m[i] = writedata & wm;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        ec_m[i]   = '0;
        mask_m[i] = '0;
      end
    end
  end

  // Every-cycle compare of all three instances against the model.
  always @(negedge clk) begin
    logic [31:0] exp_rd, act_rd;
    logic        act_irq;
    for (int i = 0; i < 3; i++) begin
      case (address)
        2'd0:    exp_rd = h(cyc - sstg(i) + 1) & wmask(i);
        2'd2:    exp_rd = mask_m[i];
        2'd3:    exp_rd = ec_m[i];
        default: exp_rd = 32'h0;
      endcase
      act_rd  = (i == 0) ? rd0  : (i == 1) ? rd1  : rd2;
      act_irq = (i == 0) ? irq0 : (i == 1) ? irq1 : irq2;
      chk($sformatf("model_rd[%0d] addr=%0d cyc=%0d", i, address, cyc), act_rd, exp_rd);
      chk($sformatf("model_irq[%0d] cyc=%0d", i, cyc), 32'(act_irq), 32'(|(ec_m[i] & mask_m[i])));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic clear_all();
    wr(2'd3, 32'hFFFF_FFFF);
    wr(2'd3, 32'hFFFF_FFFF);
  endtask

  initial begin
    reset_n    = 1'b1;
    in_port    = 32'hFFFF_FFFF;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    #1 reset_n = 1'b0;

    // Reset held with bus high: everything reads 0.
    step(); step();
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      chk($sformatf("reset_rd addr=%0d", a), rd0, 32'h0);
      chk("reset_irq", 32'(irq0), 32'h0);
    end

    // Release: held-high bus yields a full rising capture after 3 edges.
    reset_n = 1'b1;
    step(); step();
    address = 2'd3; #1;
    chk("post_reset_ec_2edges", rd0, 32'h0);
    step();
    chk("post_reset_ec_3edges", rd0, 32'hFFFF_FFFF);
    clear_all();

    // DATA path latency and write-ignore.
    in_port = 32'hDEAD_BEEF;
    step();
    address = 2'd0; #1;
    chk("data_after_1edge", rd0, 32'hFFFF_FFFF);
    step();
    chk("data_after_2edges", rd0, 32'hDEAD_BEEF);
    wr(2'd0, 32'h0);
    address = 2'd0; #1;
    chk("data_write_ignored", rd0, 32'hDEAD_BEEF);

    // Capture and irq on bit 4, then W1C.
    in_port = 32'h0;
    repeat (5) step();
    clear_all();
    wr(2'd2, 32'h10);
    in_port = 32'h10;
    step(); step();
    in_port = 32'h0;
    step();
    address = 2'd3; #1;
    chk("bit4_ec", rd0, 32'h10);
    chk("bit4_irq", 32'(irq0), 32'h1);
    wr(2'd3, 32'h10);
    address = 2'd3; #1;
    chk("bit4_cleared_ec", rd0, 32'h0);
    chk("bit4_cleared_irq", 32'(irq0), 32'h0);

    // Mask does not gate capture; unmask raises irq next cycle.
    wr(2'd2, 32'h0);
    in_port = 32'h80;
    step(); step();
    in_port = 32'h0;
    step();
    address = 2'd3; #1;
    chk("bit7_masked_ec", rd0, 32'h80);
    chk("bit7_masked_irq", 32'(irq0), 32'h0);
    wr(2'd2, 32'h80);
    chk("bit7_unmask_irq", 32'(irq0), 32'h1);

    // Set wins over a same-edge clear.
    wr(2'd3, 32'h80);
    address = 2'd3; #1;
    chk("bit7_clear", rd0, 32'h0);
    chk("bit7_clear_irq", 32'(irq0), 32'h0);
    in_port = 32'h80;
    step(); step();
    wr(2'd3, 32'h80);
    address = 2'd3; #1;
    chk("set_wins_ec", rd0, 32'h80);
    chk("set_wins_irq", 32'(irq0), 32'h1);
    wr(2'd3, 32'h80);
    address = 2'd3; #1;
    chk("set_wins_then_clear", rd0, 32'h0);

    // Edge types on bit 0.
    wr(2'd2, 32'h0);
    in_port = 32'h0;
    repeat (5) step();
    clear_all();
    in_port = 32'h1;
    repeat (4) step();
    address = 2'd3; #1;
    chk("rise_on_rising", rd0, 32'h1);
    chk("rise_on_falling", rd1, 32'h0);
    chk("rise_on_any", rd2, 32'h1);
    clear_all();
    in_port = 32'h0;
    repeat (4) step();
    address = 2'd3; #1;
    chk("fall_on_rising", rd0, 32'h0);
    chk("fall_on_falling", rd1, 32'h1);
    chk("fall_on_any", rd2, 32'h1);

    // Narrow width: upper readdata bits are zero.
    clear_all();
    in_port = 32'hFFFF_FFFF;
    repeat (4) step();
    address = 2'd0; #1;
    chk("w8_data", rd1, 32'h0000_00FF);
    chk("w8_data_s3", rd2, 32'h0000_00FF);
    wr(2'd2, 32'hFFFF_FFFF);
    address = 2'd2; #1;
    chk("w8_mask", rd1, 32'h0000_00FF);
    in_port = 32'h0;
    repeat (4) step();
    address = 2'd3; #1;
    chk("w8_ec", rd1, 32'h0000_00FF);

    // Mid-operation asynchronous reset.
    clear_all();
    wr(2'd2, 32'hF);
    in_port = 32'hF;
    repeat (3) step();
    address = 2'd3; #1;
    chk("pre_reset_ec", rd0, 32'hF);
    chk("pre_reset_irq", 32'(irq0), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_ec", rd0, 32'h0);
    chk("async_reset_irq", 32'(irq0), 32'h0);
    address = 2'd2; #1;
    chk("async_reset_mask", rd0, 32'h0);
    step();
    reset_n = 1'b1;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vectadd_from_hw_data.md
# vectadd_from_hw_data

Avalon-MM slave input port that returns status and results from the vector-add hardware to the processor. It is the read-side counterpart of the `to_hw_data` output port. The block:
- synchronizes a `WIDTH`-bit hardware bus into the `clk` domain;
- exposes the current value to software;
- latches per-bit edge events in a sticky edge-capture register;
- raises a maskable level interrupt.

## Interface
Parameters:
- `WIDTH`, 32, width of `in_port` and of the data, mask and edge-capture registers (1..32).
- `SYNC_STAGES`, 2, depth of the input synchronizer flop chain (2..4).
- `EDGE_TYPE`, 0, edge that sets a capture bit: 0 = rising, 1 = falling, 2 = any.

Ports:
- `clk`  in  1  the only clock; all registers update on its rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `address`  in  2  Avalon word address.
- `chipselect`  in  1  Avalon slave select.
- `write_n`  in  1  Avalon write strobe, active-low.
- `writedata`  in  32  Avalon write data.
- `in_port`  in  `WIDTH`  hardware input bus, asynchronous to `clk`.
- `readdata`  out  32  Avalon read data, zero-extended above `WIDTH`.
- `irq`  out  1  level interrupt to the processor.

## Operation
- **Synchronizer:** `s[0] <= in_port`, `s[k] <= s[k-1]`. The synchronized value `din = s[SYNC_STAGES-1]`. A register `prev <= din` holds the previous value.
- **Edge detect, per bit:**
  - rising: `din & ~prev`
  - falling: `~din & prev`
  - any: `din ^ prev`
- **Register map:**
  - 0 = DATA: read-only, returns `din`; writes ignored.
  - 1 = reserved: reads 0; writes ignored.
  - 2 = IRQMASK: read/write, `WIDTH` bits.
  - 3 = EDGECAPTURE: read returns sticky bits; a write clears each bit whose `writedata` bit is 1 (write-1-to-clear).
- **Write qualifier:** `chipselect && !write_n`. Writedata bits above `WIDTH` are ignored.
- **Reads:** zero wait states, zero read latency. `readdata` is a combinational mux of `address` over the registers, and is valid in the same cycle the address is presented. Bits above `WIDTH` read as 0.
- **Edge-capture update, per bit:** `ec_next = edge | (ec & ~clr)`. A new edge in the same cycle as a clear of that bit leaves the bit set (set wins).
- **Interrupt:** `irq = |(edgecapture & irqmask)`, driven only from registers so it cannot glitch. It stays high until software clears every unmasked captured bit or masks it.
- **Mask does not gate capture:** masking a bit never prevents that bit from being captured. Unmasking an already-set capture bit raises `irq` on the cycle after the mask write.
- **Reset (asserting `reset_n`=0 at any time, including mid-operation):** clears the synchronizer, `prev`, IRQMASK and EDGECAPTURE. `irq`=0 and `readdata`=0 for every address while held. On release, all-zero `prev` and synchronizer mean a bus held high produces a rising edge `SYNC_STAGES` cycles later (intended; software clears EDGECAPTURE after init).

## Timing
- **Input path:** `in_port` changes before clock edge N. `din` reflects it after edge N+`SYNC_STAGES`-1. Edge N+`SYNC_STAGES` sets EDGECAPTURE. `irq` rises right after that edge when the bit is masked in.
  - Default `SYNC_STAGES`=2: DATA visible after edge 2, capture and irq after edge 3.
- **Pulse width:** pulses shorter than one `clk` period may be missed. Pulses of at least two periods are guaranteed to be captured.
- **IRQMASK write:** takes effect at the write edge; `irq` follows in the same post-edge cycle.
- **EDGECAPTURE clear:** takes effect at the write edge; `irq` drops after that edge unless another unmasked bit is set.

## Test plan
- **Reset:** hold `reset_n`=0 with `in_port`=32'hFFFF_FFFF → `readdata`=0 at addresses 0–3, `irq`=0. Release; after 3 edges, EDGECAPTURE=32'hFFFF_FFFF (rising).
- **Data read:** drive `in_port`=32'hDEAD_BEEF → DATA reads 32'hDEAD_BEEF exactly 2 edges later, and not after 1. Writing 32'h0 to address 0 leaves DATA unchanged.
- **Capture and irq:** IRQMASK=32'h0000_0010; pulse bit 4 high for 2 cycles → EDGECAPTURE=32'h10 and `irq`=1. Write 32'h10 to address 3 → EDGECAPTURE=0, `irq`=0 next cycle.
- **Mask and set-wins:**
  - Set bit 7 with mask 0 → `irq` stays 0; then write IRQMASK=32'h80 → `irq`=1 the next cycle.
  - Issue a clear of bit 7 in the same cycle a new bit-7 edge is detected → bit remains 1.
- **Edge types:** `EDGE_TYPE`=1 toggles bit 0 high then low → only the fall captures. `EDGE_TYPE`=2 → both edges capture.
- **Mid-operation reset and narrow width:**
  - Assert reset while EDGECAPTURE=32'hF and IRQMASK=32'hF → both 0 and `irq`=0 immediately, asynchronously.
  - With `WIDTH`=8, reads of addresses 0, 2 and 3 have `readdata[31:8]`=0.
